// File: rtl/flag_timing_pkg.sv
// rtl/flag_timing_pkg.sv - elapsed-time flag constants and time-to-cycle conversion
package flag_timing_pkg;

    localparam int NUM_FLAGS = 8;

    // Flag index of the longest interval; it also sets the terminal count
    localparam int IDX_2S = 6;

    // Flag thresholds in ns, in output-port order:
    // 250 ns, 42 us, 100 us, 1640 us, 4100 us, 15000 us, 2 s, 250 ms
    localparam logic [63:0] T_NS [NUM_FLAGS] = '{
        64'd250,
        64'd42_000,
        64'd100_000,
        64'd1_640_000,
        64'd4_100_000,
        64'd15_000_000,
        64'd2_000_000_000,
        64'd250_000_000
    };

    // Cycles needed to cover t_ns at clk_hz, rounded up so a flag never fires early
    function automatic logic [63:0] cycles_for(input logic [63:0] t_ns, input logic [63:0] clk_hz);
        return (t_ns * clk_hz + 64'd999_999_999) / 64'd1_000_000_000;
    endfunction

endpackage

// File: rtl/flag_threshold_cmp.sv
// rtl/flag_threshold_cmp.sv - registered "count reached threshold" flag
module flag_threshold_cmp #(
    parameter int               CNT_W  = 27,
    parameter logic [CNT_W-1:0] THRESH = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count_next,
    output logic             flag
);

    // Flag tracks the count value being loaded on this same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag <= 1'b0;
        end else begin
            flag <= (count_next >= THRESH);
        end
    end

endmodule

// File: rtl/flag_controller.sv
// rtl/flag_controller.sv - elapsed-time flags since restart; FLAG_SATURATE_EN holds at 2 s instead of wrapping
module flag_controller #(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic flag_rst,
    output logic flag_250ns,
    output logic flag_42us,
    output logic flag_100us,
    output logic flag_1640us,
    output logic flag_4100us,
    output logic flag_15000us,
    output logic flag_2s,
    output logic flag_250ms
);

    import flag_timing_pkg::*;

    localparam logic [63:0]      HZ   = 64'(CLK_HZ);
    localparam logic [CNT_W-1:0] N_2S = CNT_W'(cycles_for(T_NS[IDX_2S], HZ));

    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic [NUM_FLAGS-1:0] flags;

    // Next elapsed count: restart wins, then terminal handling, else advance
    always_comb begin
        count_next = count + CNT_W'(1);
        if (flag_rst) begin
            count_next = '0;
        end else if (count == N_2S) begin
`ifdef FLAG_SATURATE_EN
            count_next = N_2S;
`else
            count_next = '0;
`endif
        end
    end

    // Elapsed-cycle counter; an asynchronous reset discards elapsed time
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
            flag_threshold_cmp #(
                .CNT_W  (CNT_W),
                .THRESH (CNT_W'(cycles_for(T_NS[gi], HZ)))
            ) u_cmp (
                .clk        (clk),
                .rst        (rst),
                .count_next (count_next),
                .flag       (flags[gi])
            );
        end
    endgenerate

    assign flag_250ns   = flags[0];
    assign flag_42us    = flags[1];
    assign flag_100us   = flags[2];
    assign flag_1640us  = flags[3];
    assign flag_4100us  = flags[4];
    assign flag_15000us = flags[5];
    assign flag_2s      = flags[6];
    assign flag_250ms   = flags[7];

endmodule

// File: tb/tb_flag_controller.sv
// tb/tb_flag_controller.sv - randomized restart stimulus against an elapsed-time reference model
module tb_flag_controller;

    // 20 kHz keeps the 2 s wrap within a short run; thresholds worked by hand:
    // 250ns->1, 42us->1, 100us->2, 1640us->33, 4100us->82, 15000us->300, 2s->40000, 250ms->5000
    localparam int HZ   = 20_000;
    localparam int N2   = 40_000;
    localparam int N [8] = '{1, 1, 2, 33, 82, 300, 40_000, 5_000};

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic flag_rst = 1'b1;
    logic flag_250ns, flag_42us, flag_100us, flag_1640us;
    logic flag_4100us, flag_15000us, flag_2s, flag_250ms;
    logic [7:0] obs;

    int vectors     = 0;
    int miscompares = 0;
    int elapsed     = 0;

    flag_controller #(
        .CLK_HZ (HZ),
        .CNT_W  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flag_rst     (flag_rst),
        .flag_250ns   (flag_250ns),
        .flag_42us    (flag_42us),
        .flag_100us   (flag_100us),
        .flag_1640us  (flag_1640us),
        .flag_4100us  (flag_4100us),
        .flag_15000us (flag_15000us),
        .flag_2s      (flag_2s),
        .flag_250ms   (flag_250ms)
    );

    always #5 clk = ~clk;

    assign obs = {flag_250ms, flag_2s, flag_15000us, flag_4100us,
                  flag_1640us, flag_100us, flag_42us, flag_250ns};

    task automatic check_flags(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s elapsed=%0d: got %b expected %b", tag, elapsed, got, exp);
        end
    endtask

    function automatic logic [7:0] expected_flags(input int e);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = (e >= N[i]);
        return r;
    endfunction

    // One clock edge with the given restart level, then compare on the falling edge
    task automatic step(input logic fr, input string tag);
        flag_rst = fr;
        @(posedge clk);
        if (fr) begin
            elapsed = 0;
        end else begin
`ifdef FLAG_SATURATE_EN
            elapsed = (elapsed + 1 > N2) ? N2 : elapsed + 1;
`else
            elapsed = (elapsed + 1) % (N2 + 1);
`endif
        end
        @(negedge clk);
        check_flags(tag, obs, expected_flags(elapsed));
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 check_flags("reset", obs, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step(1'b1, "restart_hold");

        repeat (400) step(1'b0, "ramp");

        step(1'b1, "restart");
        repeat (32) step(1'b0, "pre_1640");
        step(1'b1, "restart_wins");

        repeat (3000) step(($urandom_range(0, 59) == 0), "random");

        repeat (500) step(1'b1, "restart_long");

        repeat (150) step(1'b0, "pre_async");
        #2 rst = 1'b0;
        #1 elapsed = 0;
        check_flags("async_rst", obs, 8'h00);
        #1 rst = 1'b1;
        repeat (400) step(1'b0, "post_rst");

        step(1'b1, "restart");
        repeat (N2 + 400) step(1'b0, "terminal");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
